// File: rtl/address_generation_unit.sv
// Pipelined address generation: branch/JAL/JALR targets, load/store effective
// addresses, link address and misalignment flags behind a one-entry output register.
module address_generation_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] immediate,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] address,
  output logic [XLEN-1:0] link_address,
  output logic            target_misaligned,
  output logic            access_misaligned
);

  localparam logic [1:0] MODE_BRANCH = 2'b00;
  localparam logic [1:0] MODE_JAL    = 2'b01;
  localparam logic [1:0] MODE_JALR   = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic IALIGN32 = (IALIGN == 32);
  localparam logic XLEN64   = (XLEN == 64);

  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] rs_sum;
  logic [XLEN-1:0] link_sum;

  logic [XLEN-1:0] addr_d, addr_q;
  logic [XLEN-1:0] link_d, link_q;
  logic            tmis_d, tmis_q;
  logic            amis_d, amis_q;
  logic            valid_q;
  logic            accept;

  assign pc_sum   = pc + immediate;
  assign rs_sum   = rs1 + immediate;
  assign link_sum = pc + XLEN'(4);

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Result and flag selection for the incoming request
  always_comb begin
    addr_d = pc_sum;
    link_d = link_sum;
    tmis_d = 1'b0;
    amis_d = 1'b0;
    case (mode)
      MODE_BRANCH, MODE_JAL: begin
        addr_d = pc_sum;
        // Odd branch/JAL sums are never cleared, so bit 0 flags under any IALIGN
        tmis_d = pc_sum[0] | (IALIGN32 & pc_sum[1]);
      end
      MODE_JALR: begin
        addr_d = {rs_sum[XLEN-1:1], 1'b0};
        tmis_d = IALIGN32 & rs_sum[1];
      end
      default: begin
        addr_d = rs_sum;
        case (size)
          SIZE_BYTE: amis_d = 1'b0;
          SIZE_HALF: amis_d = rs_sum[0];
          SIZE_WORD: amis_d = (rs_sum[1:0] != 2'b00);
          default:   amis_d = XLEN64 ? (rs_sum[2:0] != 3'b000) : 1'b1;
        endcase
      end
    endcase
  end

  // Single output register; flush wins over accept, accept over drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      link_q  <= '0;
      tmis_q  <= 1'b0;
      amis_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      addr_q  <= addr_d;
      link_q  <= link_d;
      tmis_q  <= tmis_d;
      amis_q  <= amis_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid         = valid_q;
  assign address           = addr_q;
  assign link_address      = link_q;
  assign target_misaligned = tmis_q;
  assign access_misaligned = amis_q;

endmodule

// File: tb/tb_address_generation_unit.sv
// Bench for address_generation_unit: vector table through a scoreboard queue,
// plus directed backpressure, flush, wrap and asynchronous-reset sequences.
module tb_address_generation_unit;

  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  size;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] addr;
    logic [31:0] link;
    logic        tm;
    logic        am;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [1:0]  size;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] immediate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] address;
  logic [31:0] link_address;
  logic        target_misaligned;
  logic        access_misaligned;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;
  vec_t cur;
  vec_t q[$];
  vec_t tbl[13];

  address_generation_unit #(.XLEN(32), .IALIGN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .size(size), .pc(pc), .rs1(rs1), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready),
    .address(address), .link_address(link_address),
    .target_misaligned(target_misaligned), .access_misaligned(access_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s,
                              input logic [31:0] p, input logic [31:0] r,
                              input logic [31:0] i, input logic [31:0] a,
                              input logic [31:0] l, input logic t, input logic c);
    vec_t v;
    v.mode = m; v.size = s; v.pc = p; v.rs1 = r; v.imm = i;
    v.addr = a; v.link = l; v.tm = t; v.am = c;
    return v;
  endfunction

  // Reference behaviour for IALIGN=32, XLEN=32
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [31:0] s;
    r = v;
    s = (v.mode[1] == 1'b0) ? v.pc + v.imm : v.rs1 + v.imm;
    if (v.mode == 2'b10) s[0] = 1'b0;
    r.addr = s;
    r.link = v.pc + 32'd4;
    r.tm   = (v.mode != 2'b11) && (s[1:0] != 2'b00);
    r.am   = 1'b0;
    if (v.mode == 2'b11) begin
      case (v.size)
        2'b00:   r.am = 1'b0;
        2'b01:   r.am = s[0];
        2'b10:   r.am = (s[1:0] != 2'b00);
        default: r.am = 1'b1;
      endcase
    end
    return r;
  endfunction

  // Scoreboard: compare on consume, then record a new acceptance
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_out: got out_valid=1 want no result pending at %0t", $time);
        end else begin
          vec_t e;
          e = q.pop_front();
          chk("sb_address", address, e.addr);
          chk("sb_link", link_address, e.link);
          chk("sb_target_mis", 32'(target_misaligned), 32'(e.tm));
          chk("sb_access_mis", 32'(access_misaligned), 32'(e.am));
        end
      end
      if (in_valid && in_ready && !flush) q.push_back(cur);
    end
  end

  task automatic set_inputs(input vec_t v);
    mode = v.mode; size = v.size; pc = v.pc; rs1 = v.rs1; immediate = v.imm;
    cur = v;
  endtask

  // Present one request and return just after the edge that accepts it
  task automatic drive(input vec_t v);
    int n;
    set_inputs(v);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((q.size() != 0 || out_valid) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    tbl[0]  = mk(2'b00, 2'b00, 32'h0000_1000, 32'h0,         32'hFFFF_FFF0, 32'h0000_0FF0, 32'h0000_1004, 1'b0, 1'b0);
    tbl[1]  = mk(2'b10, 2'b00, 32'h0000_2000, 32'h0000_2001, 32'h0000_0004, 32'h0000_2004, 32'h0000_2004, 1'b0, 1'b0);
    tbl[2]  = mk(2'b10, 2'b00, 32'h0000_3000, 32'h0000_2001, 32'h0000_0002, 32'h0000_2002, 32'h0000_3004, 1'b1, 1'b0);
    tbl[3]  = mk(2'b11, 2'b10, 32'h0000_0040, 32'h0000_0100, 32'h0000_0002, 32'h0000_0102, 32'h0000_0044, 1'b0, 1'b1);
    tbl[4]  = mk(2'b11, 2'b01, 32'h0000_0040, 32'h0000_0100, 32'h0000_0002, 32'h0000_0102, 32'h0000_0044, 1'b0, 1'b0);
    tbl[5]  = mk(2'b11, 2'b11, 32'h0000_0040, 32'h0000_0100, 32'h0000_0002, 32'h0000_0102, 32'h0000_0044, 1'b0, 1'b1);
    tbl[6]  = mk(2'b00, 2'b00, 32'hFFFF_FFFC, 32'h0,         32'h0000_0008, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0);
    tbl[7]  = mk(2'b01, 2'b00, 32'h0000_0100, 32'h0,         32'h0000_0003, 32'h0000_0103, 32'h0000_0104, 1'b1, 1'b0);
    tbl[8]  = mk(2'b01, 2'b00, 32'h0000_0100, 32'h0,         32'h0000_0006, 32'h0000_0106, 32'h0000_0104, 1'b1, 1'b0);
    tbl[9]  = mk(2'b11, 2'b00, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'h0000_0004, 1'b0, 1'b0);
    tbl[10] = mk(2'b10, 2'b00, 32'h0000_0000, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_0004, 1'b1, 1'b0);
    tbl[11] = mk(2'b11, 2'b10, 32'h0000_0080, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0004, 32'h0000_0084, 1'b0, 1'b0);
    tbl[12] = mk(2'b00, 2'b11, 32'h0000_0200, 32'h0000_DEAD, 32'h0000_0008, 32'h0000_0208, 32'h0000_0204, 1'b0, 1'b0);

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; size = 2'b00; pc = '0; rs1 = '0; immediate = '0;
    cur = tbl[0];
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_link", link_address, 32'd0);
    chk("rst_target_mis", 32'(target_misaligned), 32'd0);
    chk("rst_access_mis", 32'(access_misaligned), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // First request: result must be visible right after the accepting edge
    drive(tbl[0]);
    chk("lat1_out_valid", 32'(out_valid), 32'd1);
    chk("lat1_address", address, 32'h0000_0FF0);

    for (int i = 1; i < 13; i++) drive(tbl[i]);
    wait_drain();

    // Backpressure: hold result for three cycles with a new request waiting
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(tbl[3]);
    set_inputs(tbl[4]);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_address", address, tbl[3].addr);
      chk("bp_link", link_address, tbl[3].link);
      chk("bp_access_mis", 32'(access_misaligned), 32'(tbl[3].am));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(tbl[5]);
    drive(tbl[6]);
    drive(tbl[1]);
    wait_drain();

    // Random burst with occasional consumer stalls
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.mode = 2'($urandom_range(0, 3));
      v.size = 2'($urandom_range(0, 3));
      v.pc   = $urandom();
      v.rs1  = $urandom();
      v.imm  = $urandom();
      v = model(v);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
      drive(v);
    end
    wait_drain();

    // Flush with an idle output: request is dropped
    @(posedge clk); #1;
    set_inputs(tbl[2]);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("flush_idle_queue", 32'(q.size()), 32'd0);

    // Flush while a result is held: both held result and new request vanish
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(tbl[0]);
    set_inputs(tbl[1]);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk("flush_held_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset while a result is held
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(tbl[7]);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_address", address, 32'd0);
    chk("arst_link", link_address, 32'd0);
    chk("arst_target_mis", 32'(target_misaligned), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    drive(tbl[12]);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/address_generation_unit.md
Name: address_generation_unit

Overview:
- Parametrised, pipelined successor to the combinational PC+immediate adder.
- Computes branch/JAL targets (PC+imm), JALR targets ((rs1+imm) with LSB cleared) and load/store effective addresses (rs1+imm).
- Also produces the link address (PC+4) and the misalignment flags.
- Sits between the decode/operand stage and the execute/memory stage, with a one-entry registered output and a valid/ready handshake.

Parameters:
- XLEN, 32, datapath width of PC, rs1, immediate and all address outputs.
- IALIGN, 32, instruction alignment in bits (32 or 16); sets the target-misalignment check.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; kills the held result and any same-cycle input.
- in_valid  input  1  request valid.
- in_ready  output  1  request can be accepted this cycle.
- mode  input  2  operation select: 00 branch, 01 JAL, 10 JALR, 11 load/store.
- size  input  2  load/store access size (log2 bytes): 00 byte, 01 half, 10 word, 11 double.
- pc  input  XLEN  instruction PC.
- rs1  input  XLEN  base register value.
- immediate  input  XLEN  sign-extended immediate from the immediate generator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- address  output  XLEN  computed target or effective address.
- link_address  output  XLEN  PC+4 (used by JAL/JALR).
- target_misaligned  output  1  branch/JAL/JALR target violates IALIGN.
- access_misaligned  output  1  load/store address not aligned to size.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, address=0, link_address=0, both flags=0.
- in_ready = !out_valid || out_ready. This is combinational, so the unit gives full throughput back-to-back.
- Accept condition: in_valid && in_ready && !flush.
  - On accept, the result is registered next edge and out_valid=1.
  - Latency is exactly 1 cycle.
- Output is held stable while out_valid && !out_ready.
  - address, link_address and both flags must not change while held.
- Drain: out_valid && out_ready && no accept → out_valid=0 next edge. Data registers may keep their stale values.
- flush=1: out_valid=0 next edge regardless of out_ready; the input is not accepted that cycle. Flush has priority over accept.
- Arithmetic: all sums are modulo 2^XLEN; carry out is discarded, so 0xFFFFFFFC+8 gives 0x00000004.
  - mode 00/01: address = pc + immediate.
  - mode 10: address = (rs1 + immediate) with bit 0 forced to 0.
  - mode 11: address = rs1 + immediate.
  - link_address = pc + 4 in every mode.
- target_misaligned applies only to mode 00/01/10; it is 0 for mode 11.
  - IALIGN=32: set if address[1] is 1 (after the JALR bit-0 clear).
  - IALIGN=16: never set, since bit 0 is always 0 after the clear.
  - Branch/JAL with an odd sum: raw bit 0 is not cleared. If raw bit 0 is 1, the flag is also set under both IALIGN values.
- access_misaligned applies only to mode 11; it is 0 otherwise.
  - size 00: never set.
  - size 01: set if address[0].
  - size 10: set if address[1:0] != 0.
  - size 11: set if address[2:0] != 0 when XLEN=64; always set when XLEN=32 (unsupported size).
- size is ignored for modes 00-10.
- Reset asserted mid-transfer: the held result is discarded immediately and in_ready returns to 1. No partial state survives reset.
- No internal FIFO beyond the single output register. Upstream must hold its inputs while in_valid && !in_ready.

Test Plan:
- Reset, then mode 00, pc=0x00001000, imm=0xFFFFFFF0 → one cycle later out_valid=1, address=0x00000FF0, link_address=0x00001004, both flags 0.
- Mode 10, rs1=0x00002001, imm=0x00000004, IALIGN=32 → address=0x00002004 (bit 0 cleared), target_misaligned=0. Repeat with imm=0x00000002 → address=0x00002002, target_misaligned=1.
- Mode 11, rs1=0x00000100, imm=0x00000002:
  - size=10 → address=0x00000102, access_misaligned=1.
  - size=01 → access_misaligned=0.
  - size=11 at XLEN=32 → access_misaligned=1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0 and outputs stable throughout.
  - Raising out_ready gives back-to-back results, one per cycle, in order, with no loss or duplication.
- Wrap and flush:
  - pc=0xFFFFFFFC, imm=8 → address=0x00000004.
  - flush=1 together with in_valid=1 → out_valid=0 next cycle and the request is dropped.
- Drop reset low while out_valid=1 and out_ready=0 → out_valid=0 and address=0 immediately, without waiting for a clock edge.
